// File: rtl/ram_test_pkg.sv
// Shared definitions for the two-port RAM test slice: read-checker states,
// default geometry and the data pattern the writer stores at every address.
package ram_test_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;
  localparam int PAT_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // Pattern word for an address: the address itself, zero-extended.
  function automatic logic [PAT_W-1:0] expected_word(input logic [PAT_W-1:0] addr);
    return addr;
  endfunction

endpackage

// File: rtl/ram_rd_cmp_pipe.sv
// Delay line that tracks each issued read for RD_LAT cycles, then compares
// the returned RAM word against the address pattern.
module ram_rd_cmp_pipe
  import ram_test_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              cmp_valid,
  output logic [ADDR_W-1:0] cmp_addr,
  output logic              mismatch
);

  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [DATA_W-1:0] exp_word;

  // NOTE: this small array is reset so reads in flight at reset never reach the compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage shift from its old value in one edge.
      vld_q[0]  <= issue_en;
      addr_q[0] <= issue_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign cmp_valid = vld_q[RD_LAT-1];
  assign cmp_addr  = addr_q[RD_LAT-1];
  assign exp_word  = DATA_W'(expected_word(PAT_W'(cmp_addr)));
  assign mismatch  = cmp_valid && (rd_data != exp_word);

endmodule

// File: rtl/ram_rd_check.sv
// Read-side checker: sweeps RAM port B while the writer's flag is high and
// reports pattern mismatches through sticky status, a count and the first bad address.
module ram_rd_check
  import ram_test_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_rd_flag,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              chk_busy,
  output logic              sweep_done,
  output logic              err_flag,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        drain_cnt_q;
  logic              cmp_valid, mismatch;
  logic [ADDR_W-1:0] cmp_addr;
  logic              err_flag_q;
  logic [ERR_W-1:0]  err_cnt_q;
  logic [ADDR_W-1:0] first_q;

  // NOTE: next state is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ram_rd_flag) state_d = ST_READ;
      ST_READ:  if (!ram_rd_flag) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (ram_rd_flag)                     state_d = ST_READ;
        else if (drain_cnt_q == DRAIN_LAST)  state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // The address advances past every issued read, so a resume from DRAIN
  // continues at the next unread word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && state_d == ST_READ) addr_q <= '0;
      else if (state_q == ST_READ)                  addr_q <= addr_q + ADDR_W'(1);
      drain_cnt_q <= (state_q == ST_DRAIN) ? drain_cnt_q + 2'd1 : 2'd0;
    end
  end

  ram_rd_cmp_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_cmp_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_en   (ram_rd_en),
    .issue_addr (addr_q),
    .rd_data    (ram_rd_data),
    .cmp_valid  (cmp_valid),
    .cmp_addr   (cmp_addr),
    .mismatch   (mismatch)
  );

  // Error state is only ever cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
      first_q    <= '0;
    end else if (mismatch) begin
      err_flag_q <= 1'b1;
      if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
      if (!err_flag_q)     first_q   <= cmp_addr;
    end
  end

  assign ram_rd_en      = (state_q == ST_READ);
  assign ram_rd_addr    = addr_q;
  assign chk_busy       = (state_q != ST_IDLE);
  assign sweep_done     = cmp_valid && (cmp_addr == '1);
  assign err_flag       = err_flag_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_ram_rd_check.sv
// Bench for ram_rd_check: two instances (RD_LAT=1/ERR_W=8 and RD_LAT=2/ERR_W=4)
// with model RAMs, checked every cycle against a transaction-level reference.
module tb_ram_rd_check;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic rst_n;

  logic              flag_a, en_a, busy_a, sw_a, ef_a;
  logic [ADDR_W-1:0] addr_a, first_a;
  logic [DATA_W-1:0] rd_a, cnt_a;
  logic              flag_b, en_b, busy_b, sw_b, ef_b;
  logic [ADDR_W-1:0] addr_b, first_b;
  logic [DATA_W-1:0] rd_b1, rd_b;
  logic [3:0]        cnt_b;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  int total = 0;
  int bad   = 0;

  // Reference model state, one slot per instance.
  bit m_read [2];
  int m_drain[2];
  int m_next [2];
  int m_cnt  [2];
  int m_first[2];
  bit m_err  [2];
  int hist   [2][8];
  int cyc = 0;

  always #5 clk = ~clk;

  ram_rd_check #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .ERR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .ram_rd_flag(flag_a), .ram_rd_en(en_a), .ram_rd_addr(addr_a),
    .ram_rd_data(rd_a), .chk_busy(busy_a), .sweep_done(sw_a), .err_flag(ef_a),
    .err_cnt(cnt_a), .first_err_addr(first_a));

  ram_rd_check #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .ERR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ram_rd_flag(flag_b), .ram_rd_en(en_b), .ram_rd_addr(addr_b),
    .ram_rd_data(rd_b), .chk_busy(busy_b), .sweep_done(sw_b), .err_flag(ef_b),
    .err_cnt(cnt_b), .first_err_addr(first_b));

  // Model RAMs with one- and two-cycle read latency.
  always @(posedge clk) begin
    rd_a  <= mem_a[addr_a];
    rd_b1 <= mem_b[addr_b];
    rd_b  <= rd_b1;
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int cmax_of(input int i);
    return (i == 0) ? 255 : 15;
  endfunction

  function automatic int word_of(input int i, input int a);
    return (i == 0) ? int'(mem_a[a]) : int'(mem_b[a]);
  endfunction

  function automatic logic cur_en(input int i);
    return (i == 0) ? en_a : en_b;
  endfunction

  function automatic int cur_addr(input int i);
    return (i == 0) ? int'(addr_a) : int'(addr_b);
  endfunction

  function automatic logic cur_sw(input int i);
    return (i == 0) ? sw_a : sw_b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      m_read[i] = 1'b0; m_drain[i] = 0; m_next[i] = 0;
      m_cnt[i]  = 0;    m_first[i] = 0; m_err[i]  = 1'b0;
      for (int j = 0; j < 8; j++) hist[i][j] = -1;
    end
  endtask

  task automatic check_all_zero();
    check("rst en_a", 32'(en_a), 0);      check("rst en_b", 32'(en_b), 0);
    check("rst addr_a", 32'(addr_a), 0);  check("rst addr_b", 32'(addr_b), 0);
    check("rst busy_a", 32'(busy_a), 0);  check("rst busy_b", 32'(busy_b), 0);
    check("rst sweep_a", 32'(sw_a), 0);   check("rst sweep_b", 32'(sw_b), 0);
    check("rst eflag_a", 32'(ef_a), 0);   check("rst eflag_b", 32'(ef_b), 0);
    check("rst ecnt_a", 32'(cnt_a), 0);   check("rst ecnt_b", 32'(cnt_b), 0);
    check("rst first_a", 32'(first_a), 0); check("rst first_b", 32'(first_b), 0);
  endtask

  task automatic cmp_inst(input int i, input string nm, input logic en, input logic [ADDR_W-1:0] addr,
                          input logic busy, input logic sw, input logic ef, input logic [7:0] cnt,
                          input logic [ADDR_W-1:0] first);
    int due;
    due = hist[i][(cyc - lat_of(i)) & 7];
    check({nm, " en"},    32'(en),    32'(m_read[i]));
    check({nm, " addr"},  32'(addr),  32'(m_next[i]));
    check({nm, " busy"},  32'(busy),  32'(m_read[i] || m_drain[i] > 0));
    check({nm, " sweep"}, 32'(sw),    32'(due == DEPTH - 1));
    check({nm, " eflag"}, 32'(ef),    32'(m_err[i]));
    check({nm, " ecnt"},  32'(cnt),   32'(m_cnt[i]));
    check({nm, " first"}, 32'(first), 32'(m_first[i]));
  endtask

  // One clock: advance the reference through the edge, then compare both instances.
  task automatic tick();
    bit f[2];
    f[0] = flag_a;
    f[1] = flag_b;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      int c = hist[i][(cyc - lat_of(i)) & 7];
      if (c >= 0 && word_of(i, c) != c) begin
        if (m_cnt[i] < cmax_of(i)) m_cnt[i]++;
        if (!m_err[i]) m_first[i] = c;
        m_err[i] = 1'b1;
      end
      hist[i][cyc & 7] = m_read[i] ? m_next[i] : -1;
      if (m_read[i]) m_next[i] = (m_next[i] + 1) % DEPTH;
      if (m_read[i]) begin
        if (!f[i]) begin m_read[i] = 1'b0; m_drain[i] = lat_of(i); end
      end else if (m_drain[i] > 0) begin
        if (f[i]) begin m_read[i] = 1'b1; m_drain[i] = 0; end
        else m_drain[i]--;
      end else if (f[i]) begin
        m_read[i] = 1'b1;
        m_next[i] = 0;
      end
    end
    cyc++;
    #1;
    cmp_inst(0, "a", en_a, addr_a, busy_a, sw_a, ef_a, cnt_a, first_a);
    cmp_inst(1, "b", en_b, addr_b, busy_b, sw_b, ef_b, {4'b0, cnt_b}, first_b);
  endtask

  task automatic run_to_addr(input int i, input int target, input int budget);
    int n = 0;
    while (!(cur_en(i) === 1'b1 && cur_addr(i) == target) && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("reach addr %0d inst %0d", target, i), 32'(n < budget), 1);
  endtask

  task automatic wait_sweep(input int i, input int budget, output int n);
    tick();
    n = 1;
    while (cur_sw(i) !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("sweep seen inst %0d", i), 32'(cur_sw(i)), 1);
  endtask

  initial begin
    int n;
    flag_a = 1'b0;
    flag_b = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      mem_a[a] = DATA_W'(a);
      mem_b[a] = DATA_W'(a);
    end
    clear_model();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_all_zero();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Clean sweeps on instance a: flag at cycle 10, first read at cycle 11.
    repeat (10) tick();
    flag_a = 1'b1;
    check("en before flag sampled", 32'(en_a), 0);
    tick();
    check("en at cycle 11", 32'(en_a), 1);
    check("first addr", 32'(addr_a), 0);
    for (int s = 0; s < 3; s++) begin
      wait_sweep(0, 100, n);
      check($sformatf("sweep %0d spacing", s), 32'(n), 64);
    end
    check("clean eflag", 32'(ef_a), 0);
    check("clean ecnt", 32'(cnt_a), 0);

    // Two corrupted words on instance a.
    flag_a = 1'b0;
    repeat (4) tick();
    check("a idle", 32'(busy_a), 0);
    mem_a[17] = 8'hFF;
    mem_a[40] = 8'h00;
    flag_a = 1'b1;
    wait_sweep(0, 100, n);
    check("corrupt sweep latency", 32'(n), 65);
    check("sweep1 eflag", 32'(ef_a), 1);
    check("sweep1 first", 32'(first_a), 17);
    check("sweep1 ecnt", 32'(cnt_a), 2);
    wait_sweep(0, 100, n);
    check("sweep2 ecnt", 32'(cnt_a), 4);
    check("sweep2 first", 32'(first_a), 17);
    flag_a = 1'b0;
    repeat (4) tick();

    // Instance b: drop flag at address 30; corrupted 29/30 make drain compares visible.
    mem_b[29] = 8'hFF;
    mem_b[30] = 8'h00;
    flag_b = 1'b1;
    run_to_addr(1, 30, 100);
    flag_b = 1'b0;
    tick();
    check("reads stop", 32'(en_b), 0);
    check("draining busy", 32'(busy_b), 1);
    repeat (2) tick();
    check("drain done", 32'(busy_b), 0);
    check("drain compares", 32'(cnt_b), 2);
    check("drain first", 32'(first_b), 29);
    mem_b[29] = 8'd29;
    mem_b[30] = 8'd30;
    flag_b = 1'b1;
    tick();
    check("restart addr", 32'(addr_b), 0);
    check("restart en", 32'(en_b), 1);

    // One-cycle flag drop: DRAIN back to READ without restarting.
    run_to_addr(1, 45, 100);
    flag_b = 1'b0;
    tick();
    check("glitch drain en", 32'(en_b), 0);
    flag_b = 1'b1;
    tick();
    check("resume en", 32'(en_b), 1);
    check("resume addr", 32'(addr_b), 46);

    // Random flag activity on both instances.
    for (int k = 0; k < 24; k++) begin
      flag_a = 1'($urandom_range(0, 1));
      flag_b = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) tick();
    end

    // Saturation of the 4-bit counter with every word corrupted.
    flag_a = 1'b0;
    flag_b = 1'b0;
    repeat (4) tick();
    for (int a = 0; a < DEPTH; a++) mem_b[a] = DATA_W'(a) ^ 8'h80;
    flag_b = 1'b1;
    repeat (40) tick();
    check("sat ecnt", 32'(cnt_b), 15);
    check("sat eflag", 32'(ef_b), 1);
    repeat (10) tick();
    check("sat hold", 32'(cnt_b), 15);

    // Reset in the middle of a sweep on instance a.
    flag_b = 1'b0;
    flag_a = 1'b1;
    run_to_addr(0, 50, 200);
    check("errors before reset", 32'(cnt_a != 0), 1);
    #1 rst_n = 1'b0;
    flag_a = 1'b0;
    #1 check_all_zero();
    clear_model();
    @(posedge clk);
    #6 rst_n = 1'b1;
    repeat (5) tick();
    check("idle after reset", 32'(busy_a), 0);
    flag_a = 1'b1;
    tick();
    check("post-reset en", 32'(en_a), 1);
    check("post-reset addr", 32'(addr_a), 0);
    repeat (70) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
